// File: rtl/alu_muldiv.sv
// Execute unit: funct-coded single-cycle ALU ops plus iterative mult/div with HI/LO (divider only with ALU_MULDIV_DIV_EN).
// Latency: 1 cycle for ALU ops and unsupported codes, WIDTH+1 cycles from accept to out_valid for mult/div.
// Backpressure: in_ready is low while iterating; no output backpressure, out_valid is a one-cycle pulse.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    typedef enum logic {IDLE, ITER} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, q, dvs;
    logic             neg_q;
    logic             accept, last, op_iter, op_signed, dz_start;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MULDIV_DIV_EN
    localparam logic [5:0] F_DIV  = 6'd26;
    localparam logic [5:0] F_DIVU = 6'd27;
    logic is_div, neg_r, dz, op_div;
    assign op_div    = (ctl == F_DIV) || (ctl == F_DIVU);
    assign dz_start  = op_div && (b == '0);
    assign op_iter   = (ctl == F_MULT) || (ctl == F_MULTU) || op_div;
    assign op_signed = (ctl == F_MULT) || (ctl == F_DIV);
`else
    assign dz_start  = 1'b0;
    assign op_iter   = (ctl == F_MULT) || (ctl == F_MULTU);
    assign op_signed = (ctl == F_MULT);
`endif

    assign abs_a = (op_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op_signed && b[WIDTH-1]) ? -b : b;

    // Single-cycle ALU
    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_err, wr_hi, wr_lo;

    assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        case (ctl)
            F_ADD:  begin sc_res = add_sum[WIDTH-1:0]; sc_carry = add_sum[WIDTH]; end
            F_SUB:  begin sc_res = sub_sum[WIDTH-1:0]; sc_carry = sub_sum[WIDTH]; end
            F_AND:  sc_res = a & b;
            F_OR:   sc_res = a | b;
            F_XOR:  sc_res = a ^ b;
            F_NOR:  sc_res = ~(a | b);
            F_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            F_MFHI: sc_res = hi;
            F_MFLO: sc_res = lo;
            F_MTHI: begin sc_res = a; wr_hi = 1'b1; end
            F_MTLO: begin sc_res = a; wr_lo = 1'b1; end
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration step; the final edge also applies sign correction to the stepped value
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_acc, step_q, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    assign mul_sum = {1'b0, acc} + (q[0] ? {1'b0, dvs} : '0);

`ifdef ALU_MULDIV_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;
    assign rem_sh   = {acc, q[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, dvs});
    assign rem_diff = rem_sh[WIDTH-1:0] - dvs;
`endif

    always_comb begin
        step_acc = mul_sum[WIDTH:1];
        step_q   = {mul_sum[0], q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        if (is_div) begin
            step_acc = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            step_q   = {q[WIDTH-2:0], rem_ge};
        end
`endif
        prod   = neg_q ? -{step_acc, step_q} : {step_acc, step_q};
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
        if (is_div) begin
            fin_lo = neg_q ? -step_q : step_q;
            fin_hi = neg_r ? -step_acc : step_acc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op_iter) state_nxt = ITER;
            ITER:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            q         <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef ALU_MULDIV_DIV_EN
            is_div    <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept && op_iter) begin
                    cnt   <= '0;
                    acc   <= '0;
                    // Divide-by-zero keeps the raw dividend so it falls out as the remainder
                    q     <= dz_start ? a : abs_a;
                    dvs   <= abs_b;
                    neg_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !dz_start;
`ifdef ALU_MULDIV_DIV_EN
                    is_div <= op_div;
                    neg_r  <= op_signed && a[WIDTH-1] && !dz_start;
                    dz     <= dz_start;
`endif
                end else if (accept) begin
                    out_valid <= 1'b1;
                    result    <= sc_res;
                    carry     <= sc_carry;
                    err       <= sc_err;
                    if (wr_hi) hi <= a;
                    if (wr_lo) lo <= a;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                acc <= step_acc;
                q   <= step_q;
                if (last) begin
                    out_valid <= 1'b1;
                    result    <= fin_lo;
                    carry     <= 1'b0;
                    hi        <= fin_hi;
                    lo        <= fin_lo;
`ifdef ALU_MULDIV_DIV_EN
                    err       <= dz;
`else
                    err       <= 1'b0;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: table of single-cycle vectors, directed multi-cycle sequences,
// and random ops checked against an arithmetic reference model (HI/LO tracked in the bench).
// A second WIDTH=8 instance covers the narrow build.
module tb_alu_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid, in_ready, cin, out_valid, carry, err;
    logic [5:0] ctl;
    logic [W-1:0] a, b, result, hi, lo;

    logic iv8, ir8, ov8, c8, e8;
    logic [5:0] ctl8;
    logic [7:0] a8, b8, r8, h8, l8;

    alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .result(result), .carry(carry),
        .err(err), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .ctl(ctl8),
        .a(a8), .b(b8), .cin(1'b0), .out_valid(ov8), .result(r8), .carry(c8),
        .err(e8), .hi(h8), .lo(l8)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] mhi = '0, mlo = '0;

    typedef struct {
        logic [5:0]  c;
        logic [31:0] x, y;
        logic        ci;
        logic [31:0] res;
        logic        co, er;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on 64-bit values
    task automatic ref_op(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic [31:0] h, input logic [31:0] l,
                          output logic [31:0] r, output logic co, output logic er,
                          output logic [31:0] nh, output logic [31:0] nl, output int lat);
        logic [32:0] s;
        logic [63:0] p;
        longint sx, sy;
        r = '0; co = 1'b0; er = 1'b0; nh = h; nl = l; lat = 1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (c)
            6'd32: begin s = {1'b0, x} + {1'b0, y} + {32'b0, ci}; r = s[31:0]; co = s[32]; end
            6'd34: begin r = x - y; co = (x >= y); end
            6'd36: r = x & y;
            6'd37: r = x | y;
            6'd38: r = x ^ y;
            6'd39: r = ~(x | y);
            6'd42: r = (sx < sy) ? 32'd1 : 32'd0;
            6'd43: r = (x < y) ? 32'd1 : 32'd0;
            6'd16: r = h;
            6'd18: r = l;
            6'd17: begin nh = x; r = x; end
            6'd19: begin nl = x; r = x; end
            6'd24: begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; r = nl; lat = 33; end
            6'd25: begin p = {32'b0, x} * {32'b0, y}; nh = p[63:32]; nl = p[31:0]; r = nl; lat = 33; end
`ifdef ALU_MULDIV_DIV_EN
            6'd26, 6'd27: begin
                lat = 33;
                if (y == 0) begin nl = '1; nh = x; er = 1'b1; end
                else if (c == 6'd26) begin p = sx / sy; nl = p[31:0]; p = sx % sy; nh = p[31:0]; end
                else begin nl = x / y; nh = x % y; end
                r = nl;
            end
`endif
            default: er = 1'b1;
        endcase
    endtask

    // All sequences begin and end at a falling edge
    task automatic start_op(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y, input logic ci);
        chk("accept_ready", in_ready, 1);
        ctl = c; a = x; b = y; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic ready_bad);
        n = 0;
        ready_bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) ready_bad = 1'b1;
        end while (!out_valid && n < 200);
    endtask

    task automatic run_op(input string nm, input logic [5:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic ci, output int n);
        logic [31:0] er_r, nh, nl;
        logic er_c, er_e, rb;
        int el;
        ref_op(c, x, y, ci, mhi, mlo, er_r, er_c, er_e, nh, nl, el);
        start_op(c, x, y, ci);
        wait_done(n, rb);
        chk({nm, "/lat"}, n, el);
        chk({nm, "/res"}, result, er_r);
        chk({nm, "/carry"}, carry, er_c);
        chk({nm, "/err"}, err, er_e);
        chk({nm, "/hi"}, hi, nh);
        chk({nm, "/lo"}, lo, nl);
        chk({nm, "/busy"}, rb, 0);
        mhi = nh;
        mlo = nl;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops[18];
        logic [31:0] r_d, h_d, l_d, ph, pl;
        logic c_d, e_d, rb;
        int n, l_dummy, cnt_ov;

        in_valid = 1'b0; ctl = '0; a = '0; b = '0; cin = 1'b0;
        iv8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0;

        tbl[0]  = '{6'd32, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0};
        tbl[1]  = '{6'd32, 32'h7,         32'h5,         1'b0, 32'hC,         1'b0, 1'b0};
        tbl[2]  = '{6'd32, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h1,         1'b1, 1'b0};
        tbl[3]  = '{6'd34, 32'h5,         32'h7,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4]  = '{6'd34, 32'h3,         32'h3,         1'b1, 32'h0,         1'b1, 1'b0};
        tbl[5]  = '{6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 1'b0};
        tbl[6]  = '{6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hFFF0_FFF0, 1'b0, 1'b0};
        tbl[7]  = '{6'd38, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0FF0_0FF0, 1'b0, 1'b0};
        tbl[8]  = '{6'd39, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h000F_000F, 1'b0, 1'b0};
        tbl[9]  = '{6'd42, 32'hFFFF_FFFE, 32'h1,         1'b0, 32'h1,         1'b0, 1'b0};
        tbl[10] = '{6'd43, 32'hFFFF_FFFE, 32'h1,         1'b0, 32'h0,         1'b0, 1'b0};
        tbl[11] = '{6'd42, 32'h1,         32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0, 1'b0};
        tbl[12] = '{6'd17, 32'h1234_5678, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 1'b0};
        tbl[13] = '{6'd16, 32'h0,         32'h0,         1'b0, 32'h1234_5678, 1'b0, 1'b0};
        tbl[14] = '{6'd19, 32'h9ABC_DEF0, 32'h0,         1'b0, 32'h9ABC_DEF0, 1'b0, 1'b0};
        tbl[15] = '{6'd18, 32'h0,         32'h0,         1'b0, 32'h9ABC_DEF0, 1'b0, 1'b0};
        tbl[16] = '{6'd63, 32'h5,         32'h5,         1'b1, 32'h0,         1'b0, 1'b1};
        tbl[17] = '{6'd0,  32'h5,         32'h5,         1'b0, 32'h0,         1'b0, 1'b1};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_err", err, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            start_op(tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].ci);
            wait_done(n, rb);
            chk($sformatf("tbl%0d/lat", i), n, 1);
            chk($sformatf("tbl%0d/res", i), result, tbl[i].res);
            chk($sformatf("tbl%0d/carry", i), carry, tbl[i].co);
            chk($sformatf("tbl%0d/err", i), err, tbl[i].er);
            ref_op(tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].ci, mhi, mlo, r_d, c_d, e_d, h_d, l_d, l_dummy);
            mhi = h_d;
            mlo = l_d;
        end

        // slt then sltu on consecutive edges
        ctl = 6'd42; a = 32'hFFFF_FFFE; b = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ov1", out_valid, 1);
        chk("b2b_slt", result, 1);
        ctl = 6'd43;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_ov2", out_valid, 1);
        chk("b2b_sltu", result, 0);

        // mult -3*7, then mflo in the out_valid cycle
        run_op("mult", 6'd24, 32'hFFFF_FFFD, 32'h7, 1'b0, n);
        chk("mult_lat33", n, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        chk("mult_ready_at_ov", in_ready, 1);
        ctl = 6'd18; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mflo_after_mult_ov", out_valid, 1);
        chk("mflo_after_mult", result, 32'hFFFF_FFEB);

`ifdef ALU_MULDIV_DIV_EN
        run_op("div", 6'd26, 32'hFFFF_FFF9, 32'h2, 1'b0, n);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        run_op("divu0", 6'd27, 32'h5, 32'h0, 1'b0, n);
        chk("divu0_lat", n, 33);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'h5);
        chk("divu0_err", err, 1);
        run_op("divmin", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'h0);
        chk("divmin_err", err, 0);
`else
        ph = mhi;
        pl = mlo;
        run_op("divu0", 6'd27, 32'h5, 32'h0, 1'b0, n);
        chk("divu0_lat", n, 1);
        chk("divu0_err", err, 1);
        chk("divu0_res", result, 0);
        chk("divu0_hi_kept", hi, ph);
        chk("divu0_lo_kept", lo, pl);
        run_op("div_nodiv", 6'd26, 32'hFFFF_FFF9, 32'h2, 1'b0, n);
        chk("div_nodiv_err", err, 1);
`endif

        // add presented during ITER of a multu must be ignored
        start_op(6'd25, 32'h3, 32'h5, 1'b0);
        repeat (5) @(negedge clk);
        ctl = 6'd32; a = 32'h1; b = 32'h1; in_valid = 1'b1;
        chk("iter_not_ready", in_ready, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(n, rb);
        chk("iter_ign_lat", n, 28);
        chk("iter_ign_res", result, 32'd15);
        chk("iter_ign_hi", hi, 0);
        chk("iter_ign_lo", lo, 32'd15);
        mhi = '0;
        mlo = 32'd15;
        @(negedge clk);
        chk("iter_ign_no_add", out_valid, 0);

        ops = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd16,
                6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27, 6'd63, 6'd5};
        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 17)], pick_val(), pick_val(),
                   1'($urandom_range(0, 1)), n);
        end

        // WIDTH=8 instance
        ctl8 = 6'd25; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov8 && n < 50);
        chk("w8_multu_lat", n, 9);
        chk("w8_multu_hi", h8, 8'hFE);
        chk("w8_multu_lo", l8, 8'h01);
        chk("w8_multu_res", r8, 8'h01);
        chk("w8_ready", ir8, 1);
        ctl8 = 6'd63; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        @(negedge clk);
        chk("w8_bad_ov", ov8, 1);
        chk("w8_bad_err", e8, 1);
        chk("w8_bad_res", r8, 0);
        chk("w8_bad_carry", c8, 0);
        chk("w8_bad_hi_kept", h8, 8'hFE);

        // Reset in the middle of an iteration
        run_op("mthi_pre", 6'd17, 32'hDEAD_BEEF, 32'h0, 1'b0, n);
        start_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_res", result, 0);
        chk("mid_rst_carry", carry, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mhi = '0;
        mlo = '0;
        cnt_ov = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt_ov++;
        end
        chk("mid_rst_no_ov", cnt_ov, 0);
        run_op("post_rst_add", 6'd32, 32'h2, 32'h3, 1'b0, n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
